led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DIV, default 5000000, clock cycles per step (10 Hz at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter MAX_STEP, default 8, highest step code; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  run switch, asynchronous; 1 = auto-sequence.
REQ-006 dir  input  1  direction switch, asynchronous; 1 = up, 0 = down.
REQ-007 mode  input  1  asynchronous; 0 = wrap, 1 = bounce.
REQ-008 step_btn  input  1  single-step pushbutton, asynchronous, active-high, already debounced.
REQ-009 step  output  4  current step code; drives the bar-graph decoder address.
REQ-010 dir_out  output  1  current direction (1 = up); drives the decoder enable/direction input.
REQ-011 tick  output  1  one-cycle pulse on every step change.
REQ-012 wrap  output  1  one-cycle pulse when the step reaches an end-point (wrap-around or bounce reversal).

Function
REQ-013 en, dir, mode and step_btn each pass through a 2-flop synchronizer before use (en_s, dir_s, mode_s, btn_s); input-to-effect latency is 2 cycles.
REQ-014 The FSM has three states: IDLE, UP and DOWN.
REQ-015 IDLE with en_s=1: go to UP if dir_s=1, otherwise DOWN; the prescaler starts at 0.
REQ-016 UP or DOWN with en_s=0: go to IDLE; step holds; the prescaler clears to 0.
REQ-017 Prescaler div_cnt is 24 bits, counts only in UP/DOWN, and resets to 0 after reaching DIV-1; the cycle at DIV-1 is an advance event.
REQ-018 In wrap mode (mode_s=0) in UP/DOWN, the state follows dir_s live; the change takes effect at the next advance event.
REQ-019 Wrap-mode advance:
  - UP: step+1; at MAX_STEP, step goes to 0 and wrap fires.
  - DOWN: step-1; at 0, step goes to MAX_STEP and wrap fires.
REQ-020 Bounce mode (mode_s=1): dir_s is ignored while running.
REQ-021 Bounce-mode advance in UP at MAX_STEP-1: step goes to MAX_STEP and the state goes to DOWN, with wrap.
REQ-022 Bounce-mode advance in DOWN at 1: step goes to 0 and the state goes to UP, with wrap.
REQ-023 Bounce mode, otherwise: step goes ±1 with no wrap.
REQ-024 A bounce-mode advance from an end-point already holding (MAX_STEP in UP, or 0 in DOWN, e.g. after a mode switch) reverses the direction, moves one step inward, and fires wrap.
REQ-025 Mode changes while running take effect at the next advance event; step is never forced.
REQ-026 Single step: a rising edge of btn_s in IDLE performs exactly one advance using the REQ-019 rules with direction dir_s; tick fires, and wrap fires at the ends.
REQ-027 btn_s edges are ignored in UP/DOWN.
REQ-028 A held button produces only one step.
REQ-029 tick and wrap are registered and go high in the cycle step takes its new value; they are never high for two consecutive cycles when DIV≥2.
REQ-030 dir_out = 1 in UP, 0 in DOWN, and dir_s in IDLE.
REQ-031 step never exceeds MAX_STEP.
REQ-032 If en_s falls in the same cycle as an advance event, the IDLE transition wins and no step occurs.

Reset
REQ-033 While rst=1, asynchronously:
  - state=IDLE, step=0, tick=0, wrap=0.
  - div_cnt=0, all synchronizer and edge-detect flops 0.
  - dir_out therefore reads 0 until dir_s updates.
REQ-034 Reset asserted mid-run aborts immediately.
REQ-035 After release with en=1, the first advance occurs 2+1+DIV cycles after deassertion.

Verification (DIV=4, MAX_STEP=8)
REQ-036 Wrap-up test: en=1, dir=1, mode=0 -> step 0,1,…,8,0 every 4 cycles; wrap high only on 8->0; tick count 9.
REQ-037 Bounce test: en=1, dir=1, mode=1, 20 advances -> step 1..8,7..0,1..4; wrap only at 8 and at 0; dir_out flips in the cycle step=8.
REQ-038 Wrap-down test: en=1, dir=0, mode=0 from reset -> step 8,7,…; wrap on the first advance (0->8).
REQ-039 Pause and single-step test: run to step=5, drop en, hold 20 cycles -> step stays 5, tick=0. Pulse step_btn 3 times with dir=1 -> step 6,7,8. A 4th pulse -> step 0 with wrap. A button held 50 cycles gives one step.
REQ-040 Simultaneous-event test: en falls so that en_s drops on the DIV-1 cycle -> no step; re-enable -> div_cnt restarts, and the first advance comes 4 cycles after the IDLE exit.
REQ-041 Reset-mid-run test: assert rst at step=6 between clock edges -> step=0 and tick=0 asynchronously; after release, step stays 0 until 2+1+4 cycles.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Step sequencer for a bar-graph LED display: free-running wrap or bounce
// sequencing with a prescaler, plus single-stepping from a pushbutton while idle.
module led_seq_ctrl #(
    parameter int DIV      = 5000000,
    parameter int MAX_STEP = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic       mode,
    input  logic       step_btn,
    output logic [3:0] step,
    output logic       dir_out,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [23:0] DIV_LAST = 24'(DIV - 1);
    localparam logic [3:0]  MAX_S    = 4'(MAX_STEP);

    state_t      state_q, state_d;
    logic [1:0]  en_sync_q, dir_sync_q, mode_sync_q, btn_sync_q;
    logic        btn_prev_q;
    logic [23:0] div_cnt_q, div_cnt_d;
    logic [3:0]  step_q, step_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;

    logic        en_s, dir_s, mode_s, btn_s;
    logic        btn_rise_s, run_s, adv_evt_s, single_s, adv_up_s, bounce_s;
    logic [5:0]  adv_res_s;
    logic        adv_rev_s, adv_wrap_s;
    logic [3:0]  adv_step_s;

    // One advance from cur: returns {reverse, wrap, new_step}. A bounce from an
    // end-point already reached reverses and steps inward in the same advance.
    function automatic logic [5:0] step_advance(input logic up, input logic bounce,
                                                input logic [3:0] cur);
        logic [5:0] res;
        res = {1'b0, 1'b0, cur};
        if (bounce) begin
            if (up) begin
                if (cur >= MAX_S)             res = {1'b1, 1'b1, MAX_S - 4'd1};
                else if (cur == MAX_S - 4'd1) res = {1'b1, 1'b1, MAX_S};
                else                          res = {1'b0, 1'b0, cur + 4'd1};
            end else begin
                if (cur == 4'd0)              res = {1'b1, 1'b1, 4'd1};
                else if (cur == 4'd1)         res = {1'b1, 1'b1, 4'd0};
                else                          res = {1'b0, 1'b0, cur - 4'd1};
            end
        end else begin
            if (up) begin
                if (cur >= MAX_S)             res = {1'b0, 1'b1, 4'd0};
                else                          res = {1'b0, 1'b0, cur + 4'd1};
            end else begin
                if (cur == 4'd0)              res = {1'b0, 1'b1, MAX_S};
                else                          res = {1'b0, 1'b0, cur - 4'd1};
            end
        end
        return res;
    endfunction

    assign en_s       = en_sync_q[1];
    assign dir_s      = dir_sync_q[1];
    assign mode_s     = mode_sync_q[1];
    assign btn_s      = btn_sync_q[1];
    assign btn_rise_s = btn_s & ~btn_prev_q;
    assign run_s      = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign adv_evt_s  = run_s && en_s && (div_cnt_q == DIV_LAST);
    assign single_s   = (state_q == ST_IDLE) && btn_rise_s;
    assign adv_up_s   = (state_q == ST_IDLE) ? dir_s : (state_q == ST_UP);
    assign bounce_s   = run_s && mode_s;
    assign adv_res_s  = step_advance(adv_up_s, bounce_s, step_q);
    assign adv_rev_s  = adv_res_s[5];
    assign adv_wrap_s = adv_res_s[4];
    assign adv_step_s = adv_res_s[3:0];

    // Two-flop synchronizers and button edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync_q   <= 2'b00;
            dir_sync_q  <= 2'b00;
            mode_sync_q <= 2'b00;
            btn_sync_q  <= 2'b00;
            btn_prev_q  <= 1'b0;
        end else begin
            en_sync_q   <= {en_sync_q[0], en};
            dir_sync_q  <= {dir_sync_q[0], dir};
            mode_sync_q <= {mode_sync_q[0], mode};
            btn_sync_q  <= {btn_sync_q[0], step_btn};
            btn_prev_q  <= btn_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping en always wins over a coincident advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_s) state_d = dir_s ? ST_UP : ST_DOWN;
                else      state_d = ST_IDLE;
            end
            ST_UP, ST_DOWN: begin
                if (!en_s) begin
                    state_d = ST_IDLE;
                end else if (mode_s) begin
                    if (adv_evt_s && adv_rev_s) state_d = (state_q == ST_UP) ? ST_DOWN : ST_UP;
                    else                        state_d = state_q;
                end else begin
                    state_d = dir_s ? ST_UP : ST_DOWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prescaler and step update; tick/wrap are registered with the new step.
    always_comb begin
        div_cnt_d = 24'd0;
        step_d    = step_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (run_s && en_s) begin
            if (div_cnt_q == DIV_LAST) div_cnt_d = 24'd0;
            else                       div_cnt_d = div_cnt_q + 24'd1;
        end else begin
            div_cnt_d = 24'd0;
        end
        if (adv_evt_s || single_s) begin
            step_d = adv_step_s;
            tick_d = 1'b1;
            wrap_d = adv_wrap_s;
        end else begin
            step_d = step_q;
            tick_d = 1'b0;
            wrap_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= 24'd0;
            step_q    <= 4'd0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            step_q    <= step_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    // Direction output: idle mirrors the synchronized switch.
    always_comb begin
        dir_out = 1'b0;
        case (state_q)
            ST_UP:   dir_out = 1'b1;
            ST_DOWN: dir_out = 1'b0;
            ST_IDLE: dir_out = dir_s;
            default: dir_out = 1'b0;
        endcase
    end

    assign step = step_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl (DIV=4, MAX_STEP=8): cycle model compared every cycle,
// plus directed scenarios with hand-computed step sequences and latencies.
module tb_led_seq_ctrl;

    localparam int DIV = 4;
    localparam int MAX = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, dir = 1'b0, mode = 1'b0, step_btn = 1'b0;
    logic [3:0] step;
    logic       dir_out, tick, wrap;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit cmp_on = 1'b1;

    int rec_step[$], rec_wrap[$], rec_dir[$], rec_cyc[$];
    int exp_b[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4};

    // model state
    bit m_en1, m_en_s, m_dir1, m_dir_s, m_mode1, m_mode_s, m_btn1, m_btn_s, m_btn_prev;
    bit m_run, m_up, m_tick, m_wrap;
    int m_phase, m_step;

    led_seq_ctrl #(.DIV(DIV), .MAX_STEP(MAX)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .step_btn(step_btn),
        .step(step), .dir_out(dir_out), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // one step by the sequencer rules, expressed as modular arithmetic / reflection
    task automatic m_advance(input bit up_in, input bit bounce);
        m_tick = 1'b1;
        if (!bounce) begin
            if (up_in) begin
                m_wrap = (m_step == MAX);
                m_step = (m_step + 1) % (MAX + 1);
            end else begin
                m_wrap = (m_step == 0);
                m_step = (m_step + MAX) % (MAX + 1);
            end
        end else begin
            if ((m_up && m_step == MAX) || (!m_up && m_step == 0)) begin
                m_up = !m_up;
                m_wrap = 1'b1;
            end
            m_step = m_step + (m_up ? 1 : -1);
            if (!m_wrap && ((m_up && m_step == MAX) || (!m_up && m_step == 0))) begin
                m_up = !m_up;
                m_wrap = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                {m_en1, m_en_s, m_dir1, m_dir_s, m_mode1, m_mode_s} = '0;
                {m_btn1, m_btn_s, m_btn_prev, m_run, m_up, m_tick, m_wrap} = '0;
                m_phase = 0;
                m_step = 0;
            end else begin
                m_tick = 1'b0;
                m_wrap = 1'b0;
                if (!m_run) begin
                    if (m_btn_s && !m_btn_prev) m_advance(m_dir_s, 1'b0);
                    if (m_en_s) begin
                        m_run = 1'b1;
                        m_up = m_dir_s;
                        m_phase = 0;
                    end
                end else if (!m_en_s) begin
                    m_run = 1'b0;
                    m_phase = 0;
                end else begin
                    if (m_phase == DIV - 1) begin
                        m_phase = 0;
                        m_advance(m_up, m_mode_s);
                    end else begin
                        m_phase++;
                    end
                    if (!m_mode_s) m_up = m_dir_s;
                end
                m_btn_prev = m_btn_s;
                m_btn_s = m_btn1;   m_btn1 = step_btn;
                m_en_s = m_en1;     m_en1 = en;
                m_dir_s = m_dir1;   m_dir1 = dir;
                m_mode_s = m_mode1; m_mode1 = mode;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("step", step, m_step);
                check("tick", tick, m_tick);
                check("wrap", wrap, m_wrap);
                check("dir_out", dir_out, m_run ? m_up : m_dir_s);
            end
        end
    end

    task automatic start(input logic e, input logic d, input logic m, output int c0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; step_btn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_step", step, 0);
        check("rst_tick", tick, 0);
        check("rst_wrap", wrap, 0);
        check("rst_dir_out", dir_out, 0);
        en = e; dir = d; mode = m;
        rst = 1'b0;
        c0 = cyc;
    endtask

    task automatic run_ticks(input int n, input int budget, input string name);
        int got = 0;
        int waited = 0;
        rec_step.delete(); rec_wrap.delete(); rec_dir.delete(); rec_cyc.delete();
        while (got < n && waited < budget) begin
            @(negedge clk);
            waited++;
            if (tick) begin
                got++;
                rec_step.push_back(int'(step));
                rec_wrap.push_back(int'(wrap));
                rec_dir.push_back(int'(dir_out));
                rec_cyc.push_back(cyc);
            end
        end
        check({name, "_ticks"}, got, n);
        while (rec_step.size() < n) begin
            rec_step.push_back(-1); rec_wrap.push_back(-1);
            rec_dir.push_back(-1); rec_cyc.push_back(-1);
        end
    endtask

    task automatic quiet(input int n, output int ticks, output int wraps);
        ticks = 0;
        wraps = 0;
        repeat (n) begin
            @(negedge clk);
            if (tick) ticks++;
            if (wrap) wraps++;
        end
    endtask

    task automatic pulse_btn(input int hold, output int ticks, output int wraps);
        int t1, w1, t2, w2;
        step_btn = 1'b1;
        quiet(hold, t1, w1);
        step_btn = 1'b0;
        quiet(4, t2, w2);
        ticks = t1 + t2;
        wraps = w1 + w2;
    endtask

    initial begin
        int c0, t, w;

        // wrap up: 1..8,0 every DIV cycles, first advance 2+1+DIV after release
        start(1'b1, 1'b1, 1'b0, c0);
        run_ticks(9, 80, "wrapup");
        en = 1'b0;
        check("wrapup_first_lat", rec_cyc[0] - c0, 7);
        check("wrapup_spacing", rec_cyc[1] - rec_cyc[0], 4);
        for (int i = 0; i < 9; i++) begin
            check("wrapup_step", rec_step[i], (i + 1) % 9);
            check("wrapup_wrap", rec_wrap[i], (i == 8) ? 1 : 0);
        end
        // sync latency of en: a tick could only come 4 cycles later, none expected
        quiet(8, t, w);
        check("wrapup_stop_ticks", t, 0);

        // bounce 20 advances
        start(1'b1, 1'b1, 1'b1, c0);
        run_ticks(20, 120, "bounce");
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("bounce_step", rec_step[i], exp_b[i]);
            check("bounce_wrap", rec_wrap[i], (i == 7 || i == 15) ? 1 : 0);
        end
        check("bounce_dir_before8", rec_dir[6], 1);
        check("bounce_dir_at8", rec_dir[7], 0);
        check("bounce_dir_at0", rec_dir[15], 1);

        // wrap down, then flip dir live
        start(1'b1, 1'b0, 1'b0, c0);
        run_ticks(3, 40, "down");
        dir = 1'b1;
        check("down_s0", rec_step[0], 8);
        check("down_w0", rec_wrap[0], 1);
        check("down_s1", rec_step[1], 7);
        check("down_s2", rec_step[2], 6);
        check("down_w2", rec_wrap[2], 0);
        run_ticks(2, 20, "dirflip");
        en = 1'b0;
        check("dirflip_s0", rec_step[0], 7);
        check("dirflip_s1", rec_step[1], 8);
        check("dirflip_dir", rec_dir[1], 1);

        // pause at 5, then single steps
        start(1'b1, 1'b1, 1'b0, c0);
        run_ticks(5, 40, "pause");
        en = 1'b0;
        check("pause_at", rec_step[4], 5);
        quiet(20, t, w);
        check("pause_ticks", t, 0);
        check("pause_step", step, 5);
        for (int i = 0; i < 4; i++) begin
            pulse_btn(3, t, w);
            check("btn_ticks", t, 1);
            check("btn_wrap", w, (i == 3) ? 1 : 0);
            check("btn_step", step, (i < 3) ? 6 + i : 0);
        end
        pulse_btn(50, t, w);
        check("held_ticks", t, 1);
        check("held_step", step, 1);

        // en_s drops on the DIV-1 cycle: no step; re-enable restarts prescaler
        start(1'b1, 1'b1, 1'b0, c0);
        run_ticks(1, 20, "simul");
        @(negedge clk);
        en = 1'b0;
        quiet(10, t, w);
        check("simul_ticks", t, 0);
        check("simul_step", step, 1);
        en = 1'b1;
        c0 = cyc;
        run_ticks(1, 20, "reen");
        check("reen_lat", rec_cyc[0] - c0, 7);
        check("reen_step", rec_step[0], 2);

        // bounce switch while sitting on the top end-point
        run_ticks(6, 40, "totop");
        check("totop_step", rec_step[5], 8);
        mode = 1'b1;
        run_ticks(1, 20, "endrev");
        check("endrev_step", rec_step[0], 7);
        check("endrev_wrap", rec_wrap[0], 1);
        check("endrev_dir", rec_dir[0], 0);
        en = 1'b0;

        // reset mid-run between edges
        start(1'b1, 1'b1, 1'b0, c0);
        run_ticks(6, 40, "midrun");
        check("midrun_at", rec_step[5], 6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_step", step, 0);
        check("async_rst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        run_ticks(1, 20, "postrst");
        check("postrst_lat", rec_cyc[0] - c0, 7);
        check("postrst_step", rec_step[0], 1);
        en = 1'b0;
        repeat (4) @(negedge clk);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
